frac_baud_generator: RTL and testbench

FRAC_BAUD_GENERATOR -- requirements
Module: frac_baud_generator

---
 rtl/uart_pkg.sv | 17 +
 rtl/baud_frac_accum.sv | 21 ++
 rtl/frac_baud_generator.sv | 87 ++++++++
 tb/tb_frac_baud_generator.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared baud divisor type, reset defaults and OSR legality helpers
package uart_pkg;
  localparam int BAUD_DIV_W = 16;
  localparam int BAUD_FRAC_W = 4;
  localparam int BAUD_DEFAULT_INT = 54;
  localparam int BAUD_DEFAULT_FRAC = 4;
  localparam int OSR_LEGAL_A = 4;
  localparam int OSR_LEGAL_B = 8;
  localparam int OSR_LEGAL_C = 16;
  typedef struct packed {
    logic [BAUD_DIV_W-1:0] int_part;
    logic [BAUD_FRAC_W-1:0] frac_part;
  } baud_div_t;
  function automatic bit osr_legal(input int osr);
    return osr == OSR_LEGAL_A || osr == OSR_LEGAL_B || osr == OSR_LEGAL_C;
  endfunction
endpackage

// File: rtl/baud_frac_accum.sv
// baud_frac_accum: fractional phase accumulator, carry stretches the current period by one cycle
module baud_frac_accum #(
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              clr,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0] sum;
  assign sum = {1'b0, acc} + {1'b0, frac};
  assign carry = sum[FRAC_W];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else if (clr) acc <= '0;
    else if (adv) acc <= sum[FRAC_W-1:0];
  end
endmodule

// File: rtl/frac_baud_generator.sv
// frac_baud_generator: oversample/bit/mid-bit strobes from an int+frac divisor; BAUD_FRAC_EN builds the fraction
module frac_baud_generator
  import uart_pkg::*;
#(
  parameter int DIV_W        = BAUD_DIV_W,
  parameter int FRAC_W       = BAUD_FRAC_W,
  parameter int OSR          = 8,
  parameter int DEFAULT_INT  = BAUD_DEFAULT_INT,
  parameter int DEFAULT_FRAC = BAUD_DEFAULT_FRAC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [DIV_W-1:0]        div_int,
  input  logic [FRAC_W-1:0]       div_frac,
  input  logic                    div_load,
  output logic                    div_ack,
  input  logic                    resync,
  output logic                    os_tick,
  output logic                    baud_tick,
  output logic                    mid_tick,
  output logic [$clog2(OSR)-1:0]  os_phase
);
  localparam int PH_W = $clog2(OSR);
  if (!osr_legal(OSR)) begin : g_bad_osr
    $error("OSR must be 4, 8 or 16");
  end
  logic [DIV_W-1:0] cnt, act_int, pend_int, div_eff, p_m1;
  logic pend_v, carry, activate;
  always_comb begin
    div_eff = (act_int == '0) ? DIV_W'(1) : act_int;
    p_m1 = div_eff - DIV_W'(1) + DIV_W'(carry);
    os_tick = en & ~resync & (cnt >= p_m1);
    baud_tick = os_tick & (os_phase == PH_W'(OSR - 1));
    mid_tick = os_tick & (os_phase == PH_W'(OSR / 2 - 1));
    activate = pend_v & (resync | ~en | baud_tick);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      os_phase <= '0;
      act_int <= DIV_W'(DEFAULT_INT);
      pend_int <= '0;
      pend_v <= 1'b0;
      div_ack <= 1'b0;
    end else begin
      div_ack <= activate;
      if (resync) begin
        cnt <= '0;
        os_phase <= '0;
      end else if (en) begin
        cnt <= os_tick ? '0 : cnt + DIV_W'(1);
        os_phase <= os_phase + PH_W'(os_tick);
      end
      // a load landing on an activation edge stays pending for the next boundary
      if (div_load) begin
        pend_int <= div_int;
        pend_v <= 1'b1;
      end else if (activate) pend_v <= 1'b0;
      if (activate) act_int <= pend_int;
    end
  end
`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] act_frac, pend_frac;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_frac <= FRAC_W'(DEFAULT_FRAC);
      pend_frac <= '0;
    end else begin
      if (div_load) pend_frac <= div_frac;
      if (activate) act_frac <= pend_frac;
    end
  end
  baud_frac_accum #(.FRAC_W(FRAC_W)) u_accum (
    .clk(clk),
    .rst_n(rst_n),
    .adv(os_tick),
    .clr(resync | activate),
    .frac(act_frac),
    .carry(carry)
  );
`else
  logic unused_frac;
  assign unused_frac = ^div_frac;
  assign carry = 1'b0;
`endif
endmodule

// File: tb/tb_frac_baud_generator.sv
// tb_frac_baud_generator: random and directed stimulus checked every cycle against a period-level model
module tb_frac_baud_generator;
  import uart_pkg::*;
  localparam int DW = 16;
  localparam int FW = 4;
  localparam int OSR = 8;
`ifdef BAUD_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n, en = 1'b0, div_load = 1'b0, resync = 1'b0;
  logic [DW-1:0] div_int = '0;
  logic [FW-1:0] div_frac = '0;
  logic div_ack, os_tick, baud_tick, mid_tick;
  logic [2:0] os_phase;
  int total = 0, bad = 0, cyc = 0, n_os = 0, n_bd = 0;
  int os_q[$], bd_q[$];
  frac_baud_generator #(
    .DIV_W(DW), .FRAC_W(FW), .OSR(OSR), .DEFAULT_INT(54), .DEFAULT_FRAC(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_int(div_int), .div_frac(div_frac),
    .div_load(div_load), .div_ack(div_ack), .resync(resync), .os_tick(os_tick),
    .baud_tick(baud_tick), .mid_tick(mid_tick), .os_phase(os_phase)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // reference: elapsed cycles in the current period, period length from divisor and fraction sum
  int m_cnt = 0, m_acc = 0, m_ph = 0, m_int = 54, m_frac = 4;
  bit m_pend = 1'b0, m_ack = 1'b0;
  baud_div_t m_pdiv = '0;
  always @(negedge clk) begin
    int per;
    bit e_os, e_b, e_m, act;
    if (!rst_n) begin
      m_cnt = 0; m_acc = 0; m_ph = 0; m_int = 54; m_frac = 4; m_pend = 1'b0; m_ack = 1'b0;
      chk("reset_outputs", 32'({os_tick, baud_tick, mid_tick, div_ack, os_phase}), 32'd0);
    end else begin
      per = (m_int == 0 ? 1 : m_int) + ((FRAC_ON && (m_acc + m_frac >= 2 ** FW)) ? 1 : 0);
      e_os = en && !resync && (m_cnt + 1 >= per);
      e_b = e_os && (m_ph == OSR - 1);
      e_m = e_os && (m_ph == OSR / 2 - 1);
      chk("outputs", 32'({os_tick, baud_tick, mid_tick, div_ack, os_phase}),
          32'({e_os, e_b, e_m, m_ack, 3'(m_ph)}));
      if (os_tick === 1'b1) begin n_os++; os_q.push_back(cyc); end
      if (baud_tick === 1'b1) begin n_bd++; bd_q.push_back(cyc); end
      act = m_pend && (resync || !en || e_b);
      m_ack = act;
      if (resync) begin
        m_cnt = 0; m_ph = 0;
      end else if (en) begin
        if (e_os) begin m_cnt = 0; m_ph = (m_ph + 1) % OSR; end
        else m_cnt++;
      end
      if (act || resync) m_acc = 0;
      else if (e_os) m_acc = (m_acc + m_frac) % (2 ** FW);
      if (act) begin m_int = int'(m_pdiv.int_part); m_frac = int'(m_pdiv.frac_part); end
      if (div_load) begin
        m_pend = 1'b1; m_pdiv.int_part = div_int; m_pdiv.frac_part = div_frac;
      end else if (act) m_pend = 1'b0;
    end
  end
  task automatic load(input int di, input int df);
    div_int = DW'(di); div_frac = FW'(df); div_load = 1'b1;
    @(posedge clk); #1 div_load = 1'b0;
  endtask
  task automatic wait_ack(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (div_ack === 1'b1) begin ok = 1'b1; break; end
    end
    chk(name, 32'(ok), 32'd1);
  endtask
  initial begin
    int b0, c0, t_rs, t_tk, n;
    bit ok;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; en = 1'b1;
    b0 = n_bd; c0 = cyc; os_q.delete();
    repeat (868) @(posedge clk);
    #1;
    chk("bits_in_868", 32'(n_bd - b0), 32'd2);
    chk("first_tick", 32'(os_q[0] - c0), 32'd53);
    chk("gap1", 32'(os_q[1] - os_q[0]), 32'd54);
    chk("gap2", 32'(os_q[2] - os_q[1]), 32'd54);
    chk("gap3", 32'(os_q[3] - os_q[2]), FRAC_ON ? 32'd55 : 32'd54);
    repeat (37) @(posedge clk);
    #1 load(10, 0);
    wait_ack("ack_10");
    os_q.delete(); bd_q.delete();
    repeat (250) @(posedge clk);
    #1;
    chk("os_gap_10", 32'(os_q[1] - os_q[0]), 32'd10);
    chk("baud_gap_80", 32'(bd_q[1] - bd_q[0]), 32'd80);
    load(20, 7);
    #2 rst_n = 1'b0;
    #1 chk("async_clear", 32'({os_tick, baud_tick, mid_tick, div_ack, os_phase}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (os_phase == 3'd5 && !os_tick) begin ok = 1'b1; break; end
    end
    chk("phase5_found", 32'(ok), 32'd1);
    resync = 1'b1; t_rs = cyc;
    @(posedge clk); #1 resync = 1'b0;
    t_tk = t_rs;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (os_tick === 1'b1) begin t_tk = cyc; break; end
    end
    chk("resync_gap", 32'(t_tk - t_rs), 32'd54);
    @(posedge clk); #1 chk("phase_after_resync", 32'(os_phase), 32'd1);
    n = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (os_tick === 1'b1) n++;
      if (mid_tick === 1'b1) break;
    end
    chk("mid_at_tick", 32'(n), 32'd4);
    repeat (20) @(posedge clk);
    #1 en = 1'b0; b0 = n_os;
    repeat (100) @(posedge clk);
    #1 chk("frozen_ticks", 32'(n_os - b0), 32'd0);
    en = 1'b1;
    repeat (150) @(posedge clk);
    #1 load(0, 0);
    wait_ack("ack_zero");
    repeat (5) @(posedge clk);
    #1 b0 = n_os; c0 = n_bd;
    repeat (16) @(posedge clk);
    #1;
    chk("os_every_cycle", 32'(n_os - b0), 32'd16);
    chk("baud_every_8", 32'(n_bd - c0), 32'd2);
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      resync = ($urandom_range(0, 99) == 0);
      div_load = ($urandom_range(0, 59) == 0);
      div_int = DW'($urandom_range(0, 12));
      div_frac = FW'($urandom);
      @(posedge clk); #1;
    end
    en = 1'b1; resync = 1'b0; div_load = 1'b0;
    repeat (50) @(posedge clk);
    #1 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
